// File: rtl/seg7_display_capture.sv
// Reads back a multiplexed active-low 7-segment bus and turns every change in
// a digit's character into an ASCII event on a valid/ready stream.
module seg7_display_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic [1:0]  out_pos,
  output logic        out_err,
  output logic [31:0] display,
  output logic        all_seen
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]    seg_sync_q [SYNC_STAGES];
  logic [6:0]    seg_sync_d [SYNC_STAGES];
  logic [3:0]    an_sync_q  [SYNC_STAGES];
  logic [3:0]    an_sync_d  [SYNC_STAGES];
  logic [10:0]   prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   display_q, display_d;
  logic [3:0]    err_q, err_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    seen_q, seen_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;
  logic [1:0]    out_pos_q, out_pos_d;
  logic          out_err_q, out_err_d;

  logic [6:0]  seg_s;
  logic [3:0]  an_s;
  logic [10:0] sample;
  logic        sample_ok;
  logic [1:0]  cpos;
  logic        commit;
  logic [8:0]  dec;
  logic        load_en;
  logic [1:0]  load_pos;

  // Returns {err, ascii} for an active-low segment pattern (bit6..bit0).
  function automatic logic [8:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {1'b0, 8'h30};
      7'b1111001: decode = {1'b0, 8'h31};
      7'b0100100: decode = {1'b0, 8'h32};
      7'b0110000: decode = {1'b0, 8'h33};
      7'b0011001: decode = {1'b0, 8'h34};
      7'b0010010: decode = {1'b0, 8'h35};
      7'b0000010: decode = {1'b0, 8'h36};
      7'b1111000: decode = {1'b0, 8'h37};
      7'b0000000: decode = {1'b0, 8'h38};
      7'b0010000: decode = {1'b0, 8'h39};
      7'b0100000: decode = {1'b0, 8'h41};
      7'b0000011: decode = {1'b0, 8'h42};
      7'b0100111: decode = {1'b0, 8'h43};
      7'b0100001: decode = {1'b0, 8'h44};
      7'b0000110: decode = {1'b0, 8'h45};
      7'b0001110: decode = {1'b0, 8'h46};
      7'b1000010: decode = {1'b0, 8'h47};
      7'b0001011: decode = {1'b0, 8'h48};
      7'b1101110: decode = {1'b0, 8'h49};
      7'b1110010: decode = {1'b0, 8'h4A};
      7'b0001010: decode = {1'b0, 8'h4B};
      7'b1000111: decode = {1'b0, 8'h4C};
      7'b0101010: decode = {1'b0, 8'h4D};
      7'b0101011: decode = {1'b0, 8'h4E};
      7'b0100011: decode = {1'b0, 8'h4F};
      7'b0001100: decode = {1'b0, 8'h50};
      7'b0011000: decode = {1'b0, 8'h51};
      7'b0101111: decode = {1'b0, 8'h52};
      7'b1010010: decode = {1'b0, 8'h53};
      7'b0000111: decode = {1'b0, 8'h54};
      7'b1100011: decode = {1'b0, 8'h55};
      7'b1010101: decode = {1'b0, 8'h56};
      7'b0010101: decode = {1'b0, 8'h57};
      7'b1101011: decode = {1'b0, 8'h58};
      7'b0010001: decode = {1'b0, 8'h59};
      7'b1100100: decode = {1'b0, 8'h5A};
      7'b0111111: decode = {1'b0, 8'h2D};
      7'b1110111: decode = {1'b0, 8'h5F};
      7'b1111111: decode = {1'b0, 8'h20};
      default:    decode = {1'b1, 8'h00};
    endcase
  endfunction

  always_comb begin
    seg_sync_d[0] = seg;
    an_sync_d[0]  = an;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      seg_sync_d[i] = seg_sync_q[i-1];
      an_sync_d[i]  = an_sync_q[i-1];
    end
  end

  assign seg_s  = seg_sync_q[SYNC_STAGES-1];
  assign an_s   = an_sync_q[SYNC_STAGES-1];
  assign sample = {an_s, seg_s};
  assign dec    = decode(seg_s);

  always_comb begin
    sample_ok = 1'b1;
    cpos      = 2'd0;
    case (an_s)
      4'b1110: cpos = 2'd0;
      4'b1101: cpos = 2'd1;
      4'b1011: cpos = 2'd2;
      4'b0111: cpos = 2'd3;
      default: sample_ok = 1'b0;
    endcase
  end

  // Commit on the one cycle the counter steps into STABLE_CYCLES.
  always_comb begin
    prev_d = sample;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (!sample_ok || sample != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d  = cnt_q + 1'b1;
      commit = (cnt_q == CW'(STABLE_CYCLES - 1));
    end
  end

  always_comb begin
    display_d   = display_q;
    err_d       = err_q;
    pending_d   = pending_q;
    seen_d      = seen_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_pos_d   = out_pos_q;
    out_err_d   = out_err_q;
    load_en     = 1'b0;
    load_pos    = 2'd0;

    // Descending scan so the lowest pending index wins.
    if (!out_valid_q) begin
      for (int i = 3; i >= 0; i--) begin
        if (pending_q[i]) begin
          load_en  = 1'b1;
          load_pos = 2'(i);
        end
      end
    end

    if (load_en) begin
      pending_d[load_pos] = 1'b0;
    end

    // Applied after the load clear so a same-cycle change on the loaded digit stays pending.
    if (commit) begin
      seen_d[cpos] = 1'b1;
      if (dec != {err_q[cpos], display_q[{cpos, 3'b000} +: 8]}) begin
        display_d[{cpos, 3'b000} +: 8] = dec[7:0];
        err_d[cpos]     = dec[8];
        pending_d[cpos] = 1'b1;
      end
    end

    if (out_valid_q) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (load_en) begin
      out_valid_d = 1'b1;
      out_char_d  = display_q[{load_pos, 3'b000} +: 8];
      out_err_d   = err_q[load_pos];
      out_pos_d   = load_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= '1;
        an_sync_q[i]  <= '1;
      end
      prev_q      <= '1;
      cnt_q       <= '0;
      display_q   <= 32'h20202020;
      err_q       <= '0;
      pending_q   <= '0;
      seen_q      <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_pos_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= seg_sync_d[i];
        an_sync_q[i]  <= an_sync_d[i];
      end
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      display_q   <= display_d;
      err_q       <= err_d;
      pending_q   <= pending_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_pos_q   <= out_pos_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_pos   = out_pos_q;
  assign out_err   = out_err_q;
  assign display   = display_q;
  assign all_seen  = &seen_q;

endmodule

// File: tb/tb_seg7_display_capture.sv
// Scoreboard bench: drivers queue expected {err,pos,char} events, a monitor
// pops and compares each accepted event.
module tb_seg7_display_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'b1111111;
  logic [3:0]  an = 4'b1111;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_char;
  logic [1:0]  out_pos;
  logic        out_err;
  logic [31:0] display;
  logic        all_seen;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb [$];

  always #5 clk = ~clk;

  seg7_display_capture #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_pos(out_pos), .out_err(out_err), .display(display), .all_seen(all_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [1:0] pos, input logic [7:0] ch);
    sb.push_back({err, pos, ch});
  endtask

  // Inputs change just after a rising edge, hold for n cycles.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=err%0d pos%0d char%h required=none",
                   out_err, out_pos, out_char);
        end else begin
          e = sb.pop_front();
          if ({out_err, out_pos, out_char} !== e) begin
            failures++;
            $display("FAIL event actual=err%0d pos%0d char%h required=err%0d pos%0d char%h",
                     out_err, out_pos, out_char, e[10], e[9:8], e[7:0]);
          end else begin
            $display("ok   event err%0d pos%0d char%h", out_err, out_pos, out_char);
          end
        end
      end
    end
  endtask

  initial begin
    int lat;
    fork
      monitor();
    join_none

    // Reset state with a valid pattern already presented
    an = 4'b1110;
    seg = 7'b0100000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_display", display, 32'h20202020);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_all_seen", 32'(all_seen), 32'd0);
    expect_ev(1'b0, 2'd0, 8'h41);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) lat = i;
    end
    check("latency", 32'(lat), 32'd8);
    @(posedge clk);
    #1;
    drive(4'b1110, 7'b0100000, 6);
    drain("reset_A");

    // Glitch rejection then a real '1' on digit 1
    drive(4'b1101, 7'b1111001, 3);
    drive(4'b1101, 7'b1111111, 10);
    expect_ev(1'b0, 2'd1, 8'h31);
    drive(4'b1101, 7'b1111001, 20);
    drain("glitch");

    // Scan "8","E","-","Z"
    expect_ev(1'b0, 2'd0, 8'h38);
    expect_ev(1'b0, 2'd1, 8'h45);
    expect_ev(1'b0, 2'd2, 8'h2D);
    expect_ev(1'b0, 2'd3, 8'h5A);
    drive(4'b1110, 7'b0000000, 8);
    drive(4'b1101, 7'b0000110, 8);
    drive(4'b1011, 7'b0111111, 8);
    drive(4'b0111, 7'b1100100, 8);
    drive(4'b1111, 7'b1111111, 10);
    drain("scan");
    check("scan_display", display, 32'h5A2D4538);
    check("scan_all_seen", 32'(all_seen), 32'd1);

    // Backpressure: 'A' loads at once, 'B' is overwritten by 'C'
    out_ready = 1'b0;
    expect_ev(1'b0, 2'd2, 8'h41);
    expect_ev(1'b0, 2'd2, 8'h43);
    drive(4'b1011, 7'b0100000, 8);
    drive(4'b1011, 7'b0000011, 8);
    check("stall1_valid", 32'(out_valid), 32'd1);
    check("stall1_char", {22'd0, out_pos, out_char}, {22'd0, 2'd2, 8'h41});
    drive(4'b1011, 7'b0100111, 10);
    drive(4'b1111, 7'b1111111, 5);
    check("stall2_char", {22'd0, out_pos, out_char}, {22'd0, 2'd2, 8'h41});
    check("stall_display_d2", 32'(display[23:16]), 32'h43);
    out_ready = 1'b1;
    drain("backpressure");

    // 'V', then an undecodable pattern, then invalid anodes
    expect_ev(1'b0, 2'd0, 8'h56);
    drive(4'b1110, 7'b1010101, 10);
    expect_ev(1'b1, 2'd0, 8'h00);
    drive(4'b1110, 7'b0110110, 10);
    drain("err");
    check("err_display_d0", 32'(display[7:0]), 32'h00);
    drive(4'b1100, 7'b0000000, 20);
    drive(4'b1111, 7'b0000000, 20);
    drain("invalid_an");

    // Mid-operation reset drops the in-flight 'H'
    out_ready = 1'b0;
    drive(4'b1101, 7'b0001011, 12);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_char", {22'd0, out_pos, out_char}, {22'd0, 2'd1, 8'h48});
    an = 4'b1111;
    seg = 7'b1111111;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_all_seen", 32'(all_seen), 32'd0);
    check("mid_rst_display", display, 32'h20202020);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(4'b1111, 7'b1111111, 20);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
